// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with programmable depth/width, optional
// first-word-fall-through read, almost-full/almost-empty thresholds,
// occupancy count and sticky overflow/underflow flags. Port naming follows
// the dual-clock FIFO so the two are interchangeable at a boundary.
module sync_fifo #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             wafull,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH     = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C   = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] AFULL_C   = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C  = AEMPTY_TH[ASIZE:0];
  localparam logic [ASIZE:0] CNT_ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);

  // Thresholds outside their legal range make the flags meaningless, so
  // refuse to build such a configuration at all.
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH) ||
      (AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_threshold
    $fatal(1, "sync_fifo: illegal AFULL_TH/AEMPTY_TH for this DEPTH");
  end

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic             wr_acc;
  logic             rd_acc;

  // Status decodes come straight from the registered count, so they only
  // change right after a clock edge.
  always_comb begin
    wfull   = (count == DEPTH_C);
    rempty  = (count == {(ASIZE+1){1'b0}});
    wafull  = (count >= AFULL_C);
    raempty = (count <= AEMPTY_C);
  end

  // Accept decisions use the start-of-cycle flags: a full FIFO rejects a
  // write even if a read frees a slot in the same cycle, and vice versa.
  always_comb begin
    wr_acc = winc & ~wfull;
    rd_acc = rinc & ~rempty;
  end

  // Storage array is deliberately not reset; only accepted writes land.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= {ASIZE{1'b0}};
      rptr <= {ASIZE{1'b0}};
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Occupancy: a simultaneous accepted read and write leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {(ASIZE+1){1'b0}};
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is presented combinationally; forced to zero while empty so
    // the output is defined out of reset instead of showing stale storage.
    always_comb begin
      if (rempty) begin
        rdata = {DSIZE{1'b0}};
      end else begin
        rdata = mem[rptr];
      end
    end
  end else begin : g_registered
    logic [DSIZE-1:0] rdata_q;

    // Registered read: load the head entry on an accepted read, else hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= {DSIZE{1'b0}};
      end else if (rd_acc) begin
        rdata_q <= mem[rptr];
      end else begin
        rdata_q <= rdata_q;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo. Instance d0 uses
// the registered read mode, d1 the first-word-fall-through mode.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       w0 = 1'b0, r0 = 1'b0, ec0 = 1'b0;
  logic [7:0] wd0 = 8'h00;
  logic [7:0] rd0;
  logic       full0, afull0, empty0, aempty0, ovf0, unf0;
  logic [4:0] cnt0;

  logic       w1 = 1'b0, r1 = 1'b0, ec1 = 1'b0;
  logic [7:0] wd1 = 8'h00;
  logic [7:0] rd1;
  logic       full1, afull1, empty1, aempty1, ovf1, unf1;
  logic [4:0] cnt1;

  int checks = 0;
  int errors = 0;

  sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2)) d0 (
    .clk(clk), .rst(rst), .winc(w0), .wdata(wd0), .rinc(r0), .err_clr(ec0),
    .rdata(rd0), .wfull(full0), .wafull(afull0), .rempty(empty0),
    .raempty(aempty0), .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2)) d1 (
    .clk(clk), .rst(rst), .winc(w1), .wdata(wd1), .rinc(r1), .err_clr(ec1),
    .rdata(rd1), .wfull(full1), .wafull(afull1), .rempty(empty1),
    .raempty(aempty1), .count(cnt1), .overflow(ovf1), .underflow(unf1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_cnt"},    32'(cnt0),    32'd0);
    chk({tag, "_rdata"},  32'(rd0),     32'd0);
    chk({tag, "_rempty"}, 32'(empty0),  32'd1);
    chk({tag, "_raempty"},32'(aempty0), 32'd1);
    chk({tag, "_wfull"},  32'(full0),   32'd0);
    chk({tag, "_wafull"}, 32'(afull0),  32'd0);
    chk({tag, "_ovf"},    32'(ovf0),    32'd0);
    chk({tag, "_unf"},    32'(unf0),    32'd0);
  endtask

  byte unsigned q[$];
  byte unsigned last_rd;
  byte unsigned exp_seq[16];

  initial begin
    // ---------------- reset ----------------
    step(); step();
    chk_reset0("por");
    chk("por_d1_rdata", 32'(rd1), 32'd0);
    chk("por_d1_rempty", 32'(empty1), 32'd1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      w0 = 1'b1; wd0 = 8'(8'h11 + i); step();
    end
    w0 = 1'b0; r0 = 1'b1; step();
    r0 = 1'b0;
    chk("pre_rst_cnt", 32'(cnt0), 32'd5);
    chk("pre_rst_rdata", 32'(rd0), 32'h11);
    w0 = 1'b1; wd0 = 8'h99; r0 = 1'b1;
    #2 rst = 1'b1;
    #1 chk_reset0("async_rst");
    w0 = 1'b0; r0 = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_rempty", 32'(empty0), 32'd1);
    chk("post_rst_cnt", 32'(cnt0), 32'd0);

    // ---------------- fill / overflow ----------------
    for (int i = 0; i < 16; i++) begin
      w0 = 1'b1; wd0 = 8'(i); step();
      chk("fill_cnt", 32'(cnt0), 32'(i + 1));
      chk("fill_wafull", 32'(afull0), 32'((i + 1) >= 12));
      chk("fill_wfull", 32'(full0), 32'((i + 1) == 16));
      chk("fill_raempty", 32'(aempty0), 32'((i + 1) <= 2));
    end
    wd0 = 8'hAA; step();
    w0 = 1'b0;
    chk("ovf_set", 32'(ovf0), 32'd1);
    chk("ovf_cnt", 32'(cnt0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      r0 = 1'b1; step();
      chk("drain_rdata", 32'(rd0), 32'(i));
      chk("drain_cnt", 32'(cnt0), 32'(15 - i));
    end
    chk("drain_rempty", 32'(empty0), 32'd1);
    chk("drain_unf_clear", 32'(unf0), 32'd0);
    step();
    r0 = 1'b0;
    chk("unf_set", 32'(unf0), 32'd1);
    chk("unf_rdata_hold", 32'(rd0), 32'h0F);
    chk("unf_cnt", 32'(cnt0), 32'd0);

    // ---------------- error clear ----------------
    ec0 = 1'b1; step(); ec0 = 1'b0;
    chk("clr_ovf", 32'(ovf0), 32'd0);
    chk("clr_unf", 32'(unf0), 32'd0);

    // ---------------- simultaneous at empty ----------------
    w0 = 1'b1; r0 = 1'b1; wd0 = 8'h77; step();
    w0 = 1'b0; r0 = 1'b0;
    chk("sim0_cnt", 32'(cnt0), 32'd1);
    chk("sim0_unf", 32'(unf0), 32'd1);
    chk("sim0_rdata", 32'(rd0), 32'h0F);
    ec0 = 1'b1; step(); ec0 = 1'b0;

    // ---------------- simultaneous at count 8 ----------------
    for (int i = 0; i < 7; i++) begin
      w0 = 1'b1; wd0 = 8'(8'h80 + i); step();
    end
    chk("mid_cnt", 32'(cnt0), 32'd8);
    exp_seq[0] = 8'h77; exp_seq[1] = 8'h80; exp_seq[2] = 8'h81; exp_seq[3] = 8'h82;
    for (int i = 0; i < 4; i++) begin
      w0 = 1'b1; r0 = 1'b1; wd0 = 8'(8'h90 + i); step();
      chk("sim8_cnt", 32'(cnt0), 32'd8);
      chk("sim8_rdata", 32'(rd0), 32'(exp_seq[i]));
    end
    r0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w0 = 1'b1; wd0 = 8'(8'hA0 + i); step();
    end
    chk("full_again", 32'(full0), 32'd1);

    // ---------------- simultaneous at full ----------------
    w0 = 1'b1; r0 = 1'b1; wd0 = 8'hEE; step();
    r0 = 1'b0;
    chk("sim16_cnt", 32'(cnt0), 32'd15);
    chk("sim16_ovf", 32'(ovf0), 32'd1);
    chk("sim16_rdata", 32'(rd0), 32'h83);
    wd0 = 8'hA8; step();
    w0 = 1'b0;
    chk("refill_cnt", 32'(cnt0), 32'd16);
    ec0 = 1'b1; step(); ec0 = 1'b0;
    chk("clr2_ovf", 32'(ovf0), 32'd0);
    ec0 = 1'b1; w0 = 1'b1; wd0 = 8'hEF; step();
    ec0 = 1'b0; w0 = 1'b0;
    chk("clr_vs_set_ovf", 32'(ovf0), 32'd1);
    chk("clr_vs_set_cnt", 32'(cnt0), 32'd16);

    exp_seq[0]  = 8'h84; exp_seq[1]  = 8'h85; exp_seq[2]  = 8'h86; exp_seq[3]  = 8'h90;
    exp_seq[4]  = 8'h91; exp_seq[5]  = 8'h92; exp_seq[6]  = 8'h93; exp_seq[7]  = 8'hA0;
    exp_seq[8]  = 8'hA1; exp_seq[9]  = 8'hA2; exp_seq[10] = 8'hA3; exp_seq[11] = 8'hA4;
    exp_seq[12] = 8'hA5; exp_seq[13] = 8'hA6; exp_seq[14] = 8'hA7; exp_seq[15] = 8'hA8;
    for (int i = 0; i < 16; i++) begin
      r0 = 1'b1; step();
      chk("order_rdata", 32'(rd0), 32'(exp_seq[i]));
    end
    r0 = 1'b0;
    chk("order_empty", 32'(empty0), 32'd1);

    // ---------------- wrap-around with scoreboard ----------------
    begin
      int written;
      int cyc;
      bit do_w, do_r, acc_w, acc_r;
      written = 0;
      cyc = 0;
      last_rd = 8'hA8;
      while ((written < 40 || q.size() > 0) && cyc < 600) begin
        case ((cyc / 8) % 3)
          0:       begin do_w = ($urandom_range(0, 3) != 0); do_r = ($urandom_range(0, 3) == 0); end
          1:       begin do_w = ($urandom_range(0, 3) == 0); do_r = ($urandom_range(0, 3) != 0); end
          default: begin do_w = cyc[0];                      do_r = ~cyc[0]; end
        endcase
        if (written >= 40) do_w = 1'b0;
        acc_w = do_w && (q.size() < 16);
        acc_r = do_r && (q.size() > 0);
        w0 = do_w && acc_w;
        r0 = do_r;
        wd0 = 8'($urandom_range(0, 255));
        if (acc_r) last_rd = q.pop_front();
        if (acc_w) begin
          q.push_back(wd0);
          written++;
        end
        step();
        chk("wrap_cnt", 32'(cnt0), 32'(q.size()));
        chk("wrap_rdata", 32'(rd0), 32'(last_rd));
        cyc++;
      end
      w0 = 1'b0; r0 = 1'b0;
      chk("wrap_all_written", 32'(written), 32'd40);
      chk("wrap_drained", 32'(empty0), 32'd1);
    end

    // ---------------- first-word-fall-through ----------------
    w1 = 1'b1; wd1 = 8'h5A; step();
    w1 = 1'b0;
    chk("fwft_rempty", 32'(empty1), 32'd0);
    chk("fwft_rdata", 32'(rd1), 32'h5A);
    w1 = 1'b1; wd1 = 8'h6B; step();
    w1 = 1'b0;
    chk("fwft_head_hold", 32'(rd1), 32'h5A);
    chk("fwft_cnt2", 32'(cnt1), 32'd2);
    r1 = 1'b1; step();
    chk("fwft_next", 32'(rd1), 32'h6B);
    chk("fwft_cnt1", 32'(cnt1), 32'd1);
    step();
    r1 = 1'b0;
    chk("fwft_empty", 32'(empty1), 32'd1);
    chk("fwft_unf", 32'(unf1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for paths where producer and consumer share one clock. It adds a programmable depth and width, a selectable first-word-fall-through read mode, programmable almost-full and almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. The signal naming matches the async FIFO (winc/wdata/wfull, rinc/rdata/rempty), so either block can replace the other at a producer/consumer boundary.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; DEPTH = 2^ASIZE entries.
- FWFT, 0: 0 = registered read (rdata valid 1 cycle after accepted rinc); 1 = first-word-fall-through.
- AFULL_TH, 12: wafull asserted when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2: raempty asserted when count <= AEMPTY_TH; legal range 0..DEPTH-1.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- rinc  in  1  read request.
- err_clr  in  1  clears overflow/underflow.
- rdata  out  DSIZE  read data.
- wfull  out  1  count == DEPTH.
- wafull  out  1  almost full.
- rempty  out  1  count == 0.
- raempty  out  1  almost empty.
- count  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- Storage: DEPTH x DSIZE register array, not reset. wptr and rptr are ASIZE bits wide and wrap modulo DEPTH. count is an (ASIZE+1)-bit register.
- Write accept: winc && !wfull. On accept, mem[wptr] <= wdata and wptr increments.
- Read accept: rinc && !rempty. On accept, rptr increments.
- Flags use the count value at the start of the cycle. When the FIFO is full, a write is rejected even if a read is accepted in the same cycle. When it is empty, a read is rejected even if a write is accepted in the same cycle.
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- wfull, rempty, wafull and raempty are combinational decodes of the registered count, so they are glitch-free relative to clk.
- FWFT=0: rdata is a register loaded with mem[rptr] on an accepted read; otherwise it holds its value.
- FWFT=1: rdata = mem[rptr] combinationally. It is meaningful only while rempty=0; it presents the head entry with no rinc, and an accepted rinc pops that entry.
- Rejected operations: winc && wfull sets overflow and drops the data. rinc && rempty sets underflow; rdata, pointers and count are unchanged.
- Flags stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, the set wins.
- Illegal thresholds stop elaboration via $fatal in an initial check.

## Timing
- Reset values (asynchronous, immediate on rst rising):
  - wptr = rptr = count = 0
  - rdata = 0
  - rempty = 1, raempty = 1, wfull = 0, wafull = 0
  - overflow = underflow = 0
- A write accepted at edge N gives count+1, rempty=0 and updated flags after edge N.
  - FWFT=1: the written word appears on rdata after edge N.
  - FWFT=0: the word is on rdata after edge M+1, where M is the first cycle (M >= N) in which rinc is high.
- Read accepted at edge N:
  - FWFT=0: rdata holds the popped word after edge N.
  - FWFT=1: rdata shows the next entry after edge N.
- Throughput: one write and one read per cycle sustained, with no bubbles at pointer wrap.
- Reset asserted mid-operation discards all contents and immediately restores the reset values. Operation resumes on the first edge after rst falls.

## Test plan
- Reset: assert rst during traffic with count=5. All outputs take their reset values asynchronously, and after release rempty=1, count=0.
- Fill/overflow (FWFT=0): write 0x00..0x0F, then 0xAA. wfull=1 after the 16th write, wafull=1 from count 12, overflow=1, count stays 16. Read 16 times: rdata = 0x00..0x0F in order, 0xAA never appears. One more rinc sets underflow=1.
- FWFT=1: with the FIFO empty, write 0x5A. After that edge rempty=0 and rdata=0x5A with no rinc. After rinc, rempty=1.
- Simultaneous ops:
  - count=8, winc=rinc=1 for 4 cycles: count stays 8 and data order is preserved.
  - At count=16, winc=rinc=1: the read is accepted, the write is rejected, count=15, overflow=1.
  - At count=0, winc=rinc=1: the write is accepted, the read is rejected, count=1, underflow=1.
- Wrap-around: stream 40 random words with alternating winc/rinc patterns, so both pointers wrap twice. A scoreboard matches every read, and count never exceeds 16.
- Error clear: with overflow=1, pulse err_clr and overflow goes to 0. Pulse err_clr in the same cycle as a write to the full FIFO: overflow stays 1.
